// File: rtl/han_carlson_pkg.sv
// Shared definitions for the han_carlson adder.
//   HC_WIDTH   : default operand width
//   gp_t       : (generate, propagate) pair carried through the prefix tree
//   hc_levels  : number of prefix levels for a width, log2(width) plus the even-bit fix-up level
package han_carlson_pkg;

    localparam int HC_WIDTH = 32;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // For a power-of-two width, clog2 of twice the width is log2(width) plus one level.
    function automatic int hc_levels(input int width);
        return $clog2(2 * width);
    endfunction

    localparam int HC_LEVELS = hc_levels(HC_WIDTH);

endpackage

// File: rtl/hc_prefix_cell.sv
// Parallel-prefix combine cell.
//   GRAY = 0 : black cell, o = (hi.g | hi.p & lo.g, hi.p & lo.p)
//   GRAY = 1 : gray cell, group generate only; o.p is tied low because nothing
//              downstream of a group that already reaches bit 0 needs it.
// Ports:
//   hi : (g, p) of the more significant group
//   lo : (g, p) of the adjacent less significant group
//   o  : combined group
module hc_prefix_cell
    import han_carlson_pkg::*;
#(
    parameter bit GRAY = 1'b0
) (
    input  gp_t hi,
    input  gp_t lo,
    output gp_t o
);

    assign o.g = hi.g | (hi.p & lo.g);
    assign o.p = GRAY ? 1'b0 : (hi.p & lo.p);

endmodule

// File: rtl/han_carlson.sv
// Registered Han-Carlson parallel-prefix adder: sum = (a plus b plus cin) mod 2^WIDTH.
// Kogge-Stone network on odd bit positions, then a single gray level fills in the
// even positions. Carry-in is folded into the bit-0 generate.
// Optional macro HAN_CARLSON_IN_REG_EN adds an input register stage (latency 2
// instead of 1).
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : a, b, cin valid this cycle
//   a, b      : unsigned addends, WIDTH bits
//   cin       : carry-in
//   sum       : registered sum, holds while no new result
//   cout      : registered carry-out of bit WIDTH-1
//   out_valid : one-cycle flag, sum/cout carry a new result
module han_carlson
    import han_carlson_pkg::*;
#(
    parameter int WIDTH = HC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    localparam int LEVELS = hc_levels(WIDTH);
    localparam int KS     = LEVELS - 1;

    logic [WIDTH-1:0] a_t;
    logic [WIDTH-1:0] b_t;
    logic             cin_t;
    logic             v_t;

`ifdef HAN_CARLSON_IN_REG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_t   <= '0;
            b_t   <= '0;
            cin_t <= 1'b0;
            v_t   <= 1'b0;
        end else begin
            a_t   <= a;
            b_t   <= b;
            cin_t <= cin;
            v_t   <= in_valid;
        end
    end
`else
    assign a_t   = a;
    assign b_t   = b;
    assign cin_t = cin;
    assign v_t   = in_valid;
`endif

    // tree[k][i] is the (G, P) of bit i after prefix level k; level 0 is pre-processing.
    gp_t [WIDTH-1:0] tree [0:KS];
    gp_t [WIDTH-1:0] fin;
    logic [WIDTH-1:0] pvec;
    logic [WIDTH-1:0] gfin;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pre
        assign pvec[i] = a_t[i] ^ b_t[i];
        if (i == 0) begin : g_b0
            assign tree[0][i] = '{g: (a_t[i] & b_t[i]) | (pvec[i] & cin_t), p: pvec[i]};
        end else begin : g_bn
            assign tree[0][i] = '{g: a_t[i] & b_t[i], p: pvec[i]};
        end
    end

    // Odd bits only. From level 2 on the partner distance is even, so an odd bit
    // always pairs with another odd bit; even bits pass straight through.
    // A cell whose result already spans down to bit 0 only needs G.
    for (genvar k = 1; k <= KS; k++) begin : g_lvl
        localparam int D = 1 << (k - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i % 2 == 1) && (i >= D)) begin : g_cell
                hc_prefix_cell #(.GRAY(i < (1 << k))) u_cell (
                    .hi (tree[k-1][i]),
                    .lo (tree[k-1][i-D]),
                    .o  (tree[k][i])
                );
            end else begin : g_pass
                assign tree[k][i] = tree[k-1][i];
            end
        end
    end

    // Final level: each even bit i>0 picks up the complete group (i-1:0) from its odd neighbour.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fin
        if ((i % 2 == 0) && (i > 0)) begin : g_even
            hc_prefix_cell #(.GRAY(1'b1)) u_cell (
                .hi (tree[KS][i]),
                .lo (tree[KS][i-1]),
                .o  (fin[i])
            );
        end else begin : g_keep
            assign fin[i] = tree[KS][i];
        end
        assign gfin[i] = fin[i].g;
    end

    assign carry  = {gfin[WIDTH-2:0], cin_t};
    assign sum_d  = pvec ^ carry;
    assign cout_d = gfin[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v_t;
            if (v_t) begin
                sum  <= sum_d;
                cout <= cout_d;
            end
        end
    end

endmodule

// File: tb/tb_han_carlson.sv
module tb_han_carlson;

    localparam int W = 32;
`ifdef HAN_CARLSON_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         out_valid;

    han_carlson #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t         stim[$];
    vec_t         table_v[12];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] hold_s = '0;
    logic         hold_c = 1'b0;

    task automatic check(input string name, input logic [W-1:0] es, input logic ec, input logic ev);
        checks++;
        if (sum !== es || cout !== ec || out_valid !== ev) begin
            errors++;
            $display("FAIL %s: got sum=%h cout=%b out_valid=%b, expected sum=%h cout=%b out_valid=%b",
                     name, sum, cout, out_valid, es, ec, ev);
        end
    endtask

    // Drives stim[] one entry per cycle and compares each result LAT cycles later.
    // Idle entries expect out_valid=0 with sum/cout holding the last result.
    task automatic run_stream(input string name);
        int n_vec;
        int j;
        n_vec = stim.size();
        for (int n = 0; n < n_vec + LAT - 1; n++) begin
            @(negedge clk);
            if (n < n_vec) begin
                in_valid = stim[n].v;
                a        = stim[n].a;
                b        = stim[n].b;
                cin      = stim[n].cin;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (n >= LAT - 1) begin
                j = n - (LAT - 1);
                if (stim[j].v) begin
                    hold_s = stim[j].s;
                    hold_c = stim[j].c;
                    check($sformatf("%s[%0d]", name, j), hold_s, hold_c, 1'b1);
                end else begin
                    check($sformatf("%s[%0d]", name, j), hold_s, hold_c, 1'b0);
                end
            end
        end
        stim.delete();
    endtask

    function automatic vec_t mk(input logic v, input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        vec_t       t;
        logic [W:0] r;
        r     = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
        t.v   = v;
        t.a   = va;
        t.b   = vb;
        t.cin = vc;
        t.s   = r[W-1:0];
        t.c   = r[W];
        return t;
    endfunction

    initial begin
        // {valid, a, b, cin, expected sum, expected cout}, hand-computed
        table_v[0]  = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        table_v[1]  = '{1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
        table_v[2]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        table_v[3]  = '{1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};
        table_v[4]  = '{1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0};
        table_v[5]  = '{1'b1, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        table_v[6]  = '{1'b1, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
        table_v[7]  = '{1'b1, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        table_v[8]  = '{1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1};
        table_v[9]  = '{1'b1, 32'hFFFF0000, 32'h0000FFFF, 1'b0, 32'hFFFFFFFF, 1'b0};
        table_v[10] = '{1'b1, 32'hDEADBEEF, 32'h21524111, 1'b0, 32'h00000000, 1'b1};
        table_v[11] = '{1'b1, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 32'h1E1E1E1E, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 32'h11111111;
        b        = 32'h22222222;
        cin      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'h0, 1'b0, 1'b0);

        // Release reset so that the first vector meets the first edge with rst_n=1.
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) stim.push_back(table_v[i]);
        run_stream("table");

        // One valid operation followed by three idle cycles with changing operands.
        stim.push_back('{1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0});
        stim.push_back('{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0, 1'b0});
        stim.push_back('{1'b0, 32'h80000000, 32'h80000000, 1'b1, 32'h0, 1'b0});
        stim.push_back('{1'b0, 32'h00000005, 32'h00000007, 1'b0, 32'h0, 1'b0});
        run_stream("idle_hold");

        for (int i = 0; i < 10000; i++) begin
            stim.push_back(mk(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1))));
        end
        run_stream("random");

        // Reset asserted with operands in flight: nothing accepted around it may surface.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h11111111;
        b        = 32'h22222222;
        cin      = 1'b0;
        @(negedge clk);
        a        = 32'h33333333;
        b        = 32'h44444444;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid", 32'h0, 1'b0, 1'b0);
        hold_s = '0;
        hold_c = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_flush[%0d]", i), 32'h0, 1'b0, 1'b0);
        end

        stim.push_back(mk(1'b1, 32'hCAFEF00D, 32'h35010FF2, 1'b1));
        stim.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0));
        stim.push_back(mk(1'b1, 32'h00000001, 32'hFFFFFFFF, 1'b0));
        run_stream("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
